// File: rtl/rf_pkg.sv
// Shared constants for the register-file writeback controller.
// Requester indices fix the arbitration slots of the writeback ports.
package rf_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;
    localparam int NREQ   = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request
// found at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback arbitration into the register file plus a busy
// scoreboard for WAW stalls and operand-pending reporting.
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int NREQ = rf_pkg::NREQ,
    parameter int XLEN = rf_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iss_valid,
    input  logic [REG_AW-1:0]        iss_rd,
    output logic                     iss_ready,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [REG_AW*NREQ-1:0]   req_rd,
    input  logic [XLEN*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     reg_w_EN,
    output logic [REG_AW-1:0]        rw,
    output logic [XLEN-1:0]          rw_data,
    input  logic [REG_AW-1:0]        ra,
    input  logic [REG_AW-1:0]        rb,
    output logic                     ra_busy,
    output logic                     rb_busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << REG_AW;

    logic [PW-1:0]     rr;
    logic [PW-1:0]     rr_nxt;
    logic [NREQ-1:0]   grant;
    logic              hs;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [PW-1:0]     sel_idx;
    logic              we_q;
    logic              iss_hs;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr),
        .grant (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign hs        = |req_ready;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*REG_AW +: REG_AW];
                sel_data = req_data[i*XLEN +: XLEN];
                sel_idx  = PW'(i);
            end
        end
    end

    always_comb begin
        rr_nxt = rr;
        if (hs) begin
            if (int'(sel_idx) == NREQ - 1) rr_nxt = '0;
            else                           rr_nxt = sel_idx + 1'b1;
        end
    end

    // A reset landing on the write cycle kills that write immediately.
    assign reg_w_EN  = we_q & ~rst;

    assign iss_ready = ~rst & ((iss_rd == '0) | ~busy[iss_rd]);
    assign iss_hs    = iss_valid & iss_ready & (iss_rd != '0);

    // Set is applied after clear so a same-register issue wins.
    always_comb begin
        busy_nxt = busy;
        if (reg_w_EN) busy_nxt[rw] = 1'b0;
        if (iss_hs)   busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            rw      <= '0;
            rw_data <= '0;
            rr      <= '0;
            busy    <= '0;
        end else begin
            we_q <= hs & (sel_rd != '0);
            if (hs) begin
                rw      <= sel_rd;
                rw_data <= sel_data;
            end
            rr   <= rr_nxt;
            busy <= busy_nxt;
        end
    end

    assign ra_busy = busy[ra];
    assign rb_busy = busy[rb];

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: inputs change on negedge,
// outputs are sampled 1 time unit later.
module tb_rf_wb_ctrl;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        reg_w_EN;
    logic [4:0]  rw;
    logic [31:0] rw_data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        ra_busy;
    logic        rb_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .reg_w_EN  (reg_w_EN),
        .rw        (rw),
        .rw_data   (rw_data),
        .ra        (ra),
        .rb        (rb),
        .ra_busy   (ra_busy),
        .rb_busy   (rb_busy)
    );

    task automatic clear_inputs();
        iss_valid = 1'b0;
        iss_rd    = '0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        ra        = '0;
        rb        = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 3'b111;
        iss_valid = 1'b1;
        iss_rd = 5'd3;
        #1;
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL rst_req_ready: got %b want 000", req_ready);
        end
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_iss_ready: got %b want 0", iss_ready);
        end
        @(negedge clk);
        ra = 5'd3;
        rb = 5'd5;
        #1;
        checks++;
        if (reg_w_EN !== 1'b0 || rw !== 5'd0 || rw_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_write_port: got en=%b rw=%0d data=%h want 0/0/0",
                     reg_w_EN, rw, rw_data);
        end
        checks++;
        if (ra_busy !== 1'b0 || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b%b want 00", ra_busy, rb_busy);
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_issue_write();
        do_reset();
        iss_valid = 1'b1;
        iss_rd = 5'd5;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL iw_iss_ready: got %b want 1", iss_ready);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        ra = 5'd5;
        #1;
        checks++;
        if (ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL iw_ra_busy_pending: got %b want 1", ra_busy);
        end
        req_valid = 3'b001;
        req_rd[4:0] = 5'd5;
        req_data[31:0] = 32'hDEADBEEF;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL iw_grant: got %b want 001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (reg_w_EN !== 1'b1 || rw !== 5'd5 || rw_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL iw_write: got en=%b rw=%0d data=%h want 1/5/deadbeef",
                     reg_w_EN, rw, rw_data);
        end
        checks++;
        if (ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL iw_ra_busy_write_cycle: got %b want 1", ra_busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (reg_w_EN !== 1'b0 || rw !== 5'd5 || rw_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL iw_idle_hold: got en=%b rw=%0d data=%h want 0/5/deadbeef",
                     reg_w_EN, rw, rw_data);
        end
        checks++;
        if (ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL iw_ra_busy_cleared: got %b want 0", ra_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g [4];
        logic [4:0]  exp_rd [4];
        logic [31:0] exp_d [4];
        exp_g  = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_rd = '{5'd1, 5'd2, 5'd3, 5'd1};
        exp_d  = '{32'h11, 32'h22, 32'h33, 32'h11};
        do_reset();
        req_valid = 3'b111;
        req_rd = {5'd3, 5'd2, 5'd1};
        req_data = {32'h33, 32'h22, 32'h11};
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== exp_g[k]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (reg_w_EN !== 1'b1 || rw !== exp_rd[k-1] || rw_data !== exp_d[k-1]) begin
                    errors++;
                    $display("FAIL rr_write[%0d]: got en=%b rw=%0d data=%h want 1/%0d/%h",
                             k - 1, reg_w_EN, rw, rw_data, exp_rd[k-1], exp_d[k-1]);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        ra = 5'd1;
        rb = 5'd2;
        #1;
        checks++;
        if (reg_w_EN !== 1'b1 || rw !== 5'd1 || rw_data !== 32'h11) begin
            errors++;
            $display("FAIL rr_write[3]: got en=%b rw=%0d data=%h want 1/1/11",
                     reg_w_EN, rw, rw_data);
        end
        checks++;
        if (ra_busy !== 1'b0 || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_unbusy_write: got %b%b want 00", ra_busy, rb_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_x0();
        clear_inputs();
        iss_valid = 1'b1;
        iss_rd = 5'd6;
        @(negedge clk);
        iss_valid = 1'b0;
        req_valid = 3'b010;
        req_rd[9:5] = 5'd0;
        req_data[63:32] = 32'h12345678;
        #1;
        checks++;
        if (req_ready !== 3'b010) begin
            errors++;
            $display("FAIL x0_grant: got %b want 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        ra = 5'd6;
        rb = 5'd0;
        #1;
        checks++;
        if (reg_w_EN !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_write: got en=%b want 0", reg_w_EN);
        end
        checks++;
        if (ra_busy !== 1'b1 || rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_busy: got r6=%b r0=%b want 1/0", ra_busy, rb_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_waw();
        clear_inputs();
        iss_valid = 1'b1;
        iss_rd = 5'd7;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_first_issue: got %b want 1", iss_ready);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (iss_ready !== 1'b0) begin
                errors++;
                $display("FAIL waw_stall[%0d]: got %b want 0", k, iss_ready);
            end
            @(negedge clk);
        end
        req_valid = 3'b100;
        req_rd[14:10] = 5'd7;
        req_data[95:64] = 32'hCAFE0007;
        #1;
        checks++;
        if (req_ready !== 3'b100 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_csr_hs: got grant=%b iss=%b want 100/0", req_ready, iss_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (reg_w_EN !== 1'b1 || rw !== 5'd7 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL waw_write7: got en=%b rw=%0d iss=%b want 1/7/0",
                     reg_w_EN, rw, iss_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_release: got %b want 1", iss_ready);
        end
        req_valid = 3'b001;
        req_rd[4:0] = 5'd9;
        req_data[31:0] = 32'h99;
        @(negedge clk);
        req_valid = '0;
        iss_valid = 1'b1;
        iss_rd = 5'd9;
        #1;
        checks++;
        if (reg_w_EN !== 1'b1 || rw !== 5'd9 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_setup: got en=%b rw=%0d iss=%b want 1/9/1",
                     reg_w_EN, rw, iss_ready);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        ra = 5'd9;
        #1;
        checks++;
        if (ra_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_set_wins: got %b want 1", ra_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ra = 5'd4;
        rb = 5'd9;
        req_valid = 3'b100;
        req_rd[14:10] = 5'd4;
        req_data[95:64] = 32'h44;
        #1;
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL mid_grant: got %b want 100", req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        iss_valid = 1'b1;
        iss_rd = 5'd11;
        #1;
        checks++;
        if (reg_w_EN !== 1'b0 || req_ready !== 3'b000 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_cycle: got en=%b grant=%b iss=%b want 0/000/0",
                     reg_w_EN, req_ready, iss_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        iss_valid = 1'b0;
        req_valid = 3'b111;
        req_rd = {5'd3, 5'd2, 5'd1};
        #1;
        checks++;
        if (reg_w_EN !== 1'b0 || rb_busy !== 1'b0 || ra_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_rst: got en=%b r4=%b r9=%b want 0/0/0",
                     reg_w_EN, ra_busy, rb_busy);
        end
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL mid_rr_after_rst: got %b want 001", req_ready);
        end
        // rr is now 1 after this ALU grant; reset must return it to 0.
        @(negedge clk);
        req_valid = '0;
        do_reset();
        req_valid = 3'b111;
        #1;
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL rr_reset_ptr: got %b want 001", req_ready);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_issue_write();
        test_round_robin();
        test_x0();
        test_waw();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
